// File: rtl/host_readout_ctrl_if.sv
// Bundle between the readout controller, the collider-facing snapshot buffer and the host.
// master = controller side, slave = buffer/host side.
interface host_readout_ctrl_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8
);
  logic                     in_collision_state;
  logic                     collider_ready;
  logic                     host_req;
  logic                     host_ack;
  logic [DATA_WIDTH-1:0]    rd_ux;
  logic [DATA_WIDTH-1:0]    rd_uy;
  logic [DATA_WIDTH-1:0]    rd_rho;

  logic                     capture_en;
  logic                     rd_en;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]    out_ux;
  logic [DATA_WIDTH-1:0]    out_uy;
  logic [DATA_WIDTH-1:0]    out_rho;
  logic [ADDRESS_WIDTH-1:0] out_index;
  logic                     out_valid;
  logic                     busy;
  logic                     frame_done;
  logic                     short_frame_err;

  modport master (
    input  in_collision_state, collider_ready, host_req, host_ack,
    input  rd_ux, rd_uy, rd_rho,
    output capture_en, rd_en, rd_addr,
    output out_ux, out_uy, out_rho, out_index, out_valid,
    output busy, frame_done, short_frame_err
  );

  modport slave (
    output in_collision_state, collider_ready, host_req, host_ack,
    output rd_ux, rd_uy, rd_rho,
    input  capture_en, rd_en, rd_addr,
    input  out_ux, out_uy, out_rho, out_index, out_valid,
    input  busy, frame_done, short_frame_err
  );
endinterface

// File: rtl/host_readout_ctrl.sv
// Freezes one complete collision-phase snapshot and streams it word by word to the host
// with a valid/ack handshake.
module host_readout_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DEPTH         = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  host_readout_ctrl_if.master bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ARM       = 3'd1;
  localparam logic [2:0] CAPTURE   = 3'd2;
  localparam logic [2:0] READ      = 3'd3;
  localparam logic [2:0] WAIT_DATA = 3'd4;
  localparam logic [2:0] PRESENT   = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;

  // Counter is one bit wider than an address so it can hold DEPTH itself.
  localparam int                     CNT_W     = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]         CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  logic [2:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDRESS_WIDTH-1:0] out_index_q, out_index_d;
  logic [DATA_WIDTH-1:0]    out_ux_q, out_ux_d;
  logic [DATA_WIDTH-1:0]    out_uy_q, out_uy_d;
  logic [DATA_WIDTH-1:0]    out_rho_q, out_rho_d;
  logic                     err_q, err_d;
  logic                     req_prev_q;
  logic                     coll_prev_q;

  logic req_rise;
  logic coll_rise;
  logic coll_fall;

  assign req_rise  = bus.host_req & ~req_prev_q;
  assign coll_rise = bus.in_collision_state & ~coll_prev_q;
  assign coll_fall = ~bus.in_collision_state & coll_prev_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_addr_d   = rd_addr_q;
    out_index_d = out_index_q;
    out_ux_d    = out_ux_q;
    out_uy_d    = out_uy_q;
    out_rho_d   = out_rho_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (req_rise) begin
          state_d = ARM;
          err_d   = 1'b0;
        end
      end
      ARM: begin
        if (coll_rise) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end
      end
      CAPTURE: begin
        if (bus.in_collision_state && bus.collider_ready && (cnt_q != CNT_FULL)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // A phase that ends short leaves the buffer incomplete, so wait for the next one.
        if (coll_fall) begin
          if (cnt_q == CNT_FULL) begin
            state_d   = READ;
            rd_addr_d = '0;
          end else begin
            err_d   = 1'b1;
            state_d = ARM;
          end
        end
      end
      READ: begin
        state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        out_ux_d    = bus.rd_ux;
        out_uy_d    = bus.rd_uy;
        out_rho_d   = bus.rd_rho;
        out_index_d = rd_addr_q;
        state_d     = PRESENT;
      end
      PRESENT: begin
        if (bus.host_ack) begin
          if (rd_addr_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            rd_addr_d = rd_addr_q + ADDRESS_WIDTH'(1);
            state_d   = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_addr_q   <= '0;
      out_index_q <= '0;
      out_ux_q    <= '0;
      out_uy_q    <= '0;
      out_rho_q   <= '0;
      err_q       <= 1'b0;
      req_prev_q  <= 1'b0;
      coll_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_addr_q   <= rd_addr_d;
      out_index_q <= out_index_d;
      out_ux_q    <= out_ux_d;
      out_uy_q    <= out_uy_d;
      out_rho_q   <= out_rho_d;
      err_q       <= err_d;
      req_prev_q  <= bus.host_req;
      coll_prev_q <= bus.in_collision_state;
    end
  end

  // Strobes decode straight from state so an asynchronous reset clears them immediately.
  assign bus.capture_en      = (state_q == IDLE) || (state_q == ARM) || (state_q == CAPTURE);
  assign bus.rd_en           = (state_q == READ);
  assign bus.out_valid       = (state_q == PRESENT);
  assign bus.busy            = (state_q != IDLE);
  assign bus.frame_done      = (state_q == DONE);
  assign bus.rd_addr         = rd_addr_q;
  assign bus.out_index       = out_index_q;
  assign bus.out_ux          = out_ux_q;
  assign bus.out_uy          = out_uy_q;
  assign bus.out_rho         = out_rho_q;
  assign bus.short_frame_err = err_q;

endmodule

// File: doc/host_readout_ctrl.md
HOST_READOUT_CTRL -- requirements
Module: host_readout_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each macroscopic quantity (u_x, u_y, rho).
REQ-002 Parameter ADDRESS_WIDTH, default 8, snapshot buffer address width.
REQ-003 Parameter DEPTH, default 256, lattice nodes per frame (DEPTH <= 2^ADDRESS_WIDTH).
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-006 in_collision_state  in  1  collision phase active.
REQ-007 collider_ready  in  1  one node's u_x/u_y/rho valid this cycle.
REQ-008 host_req  in  1  host requests one frame snapshot; rising edge detected.
REQ-009 host_ack  in  1  host has consumed the presented word.
REQ-010 rd_ux, rd_uy, rd_rho  in  DATA_WIDTH each  buffer read data, valid one cycle after rd_en.
REQ-011 capture_en  out  1  permits the buffer to store collider output.
REQ-012 rd_en  out  1  buffer read strobe.
REQ-013 rd_addr  out  ADDRESS_WIDTH  buffer read address.
REQ-014 out_ux, out_uy, out_rho  out  DATA_WIDTH each  presented word to host.
REQ-015 out_index  out  ADDRESS_WIDTH  node index of presented word.
REQ-016 out_valid  out  1  presented word valid.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 frame_done  out  1  one-cycle pulse after last word acknowledged.
REQ-019 short_frame_err  out  1  sticky: a frame closed with node count != DEPTH.

Function
REQ-020 FSM states SHALL be IDLE, ARM, CAPTURE, READ, WAIT_DATA, PRESENT, DONE.
REQ-021 IDLE -> ARM on host_req rising edge; other host_req edges while busy SHALL be ignored.
REQ-022 ARM -> CAPTURE only on a rising edge of in_collision_state (a phase already in progress is never captured); node counter cleared to 0.
REQ-023 CAPTURE: each cycle with in_collision_state && collider_ready increments the node counter (saturating at DEPTH).
REQ-024 CAPTURE, falling edge of in_collision_state: counter == DEPTH -> READ with rd_addr = 0; otherwise set short_frame_err, return to ARM.
REQ-025 capture_en SHALL be 1 in IDLE, ARM, CAPTURE and 0 in READ, WAIT_DATA, PRESENT, DONE (buffer frozen during readout).
REQ-026 READ: rd_en = 1 for exactly one cycle at current rd_addr, then WAIT_DATA.
REQ-027 WAIT_DATA: rd_ux/rd_uy/rd_rho registered into out_*; out_index = rd_addr; -> PRESENT with out_valid = 1 on next cycle.
REQ-028 PRESENT: out_* and out_valid SHALL hold stable until host_ack sampled 1; then out_valid = 0 next cycle.
REQ-029 On ack: rd_addr == DEPTH-1 -> DONE; else rd_addr increments, -> READ.
REQ-030 Per-word latency from READ entry to out_valid = 2 cycles; host_ack held high continuously yields one word per 3 cycles.
REQ-031 host_ack outside PRESENT SHALL be ignored.
REQ-032 DONE: frame_done = 1 for one cycle, -> IDLE.
REQ-033 short_frame_err cleared only by reset or by a new host_req accepted in IDLE.
REQ-034 rd_addr SHALL never exceed DEPTH-1; no wrap-around within a frame.
REQ-035 collider_ready outside CAPTURE SHALL not affect the counter.

Reset
REQ-036 Asserting rst (0) at any time, including mid-readout, SHALL force IDLE within the same cycle asynchronously.
REQ-037 Reset values: capture_en = 1; rd_en, out_valid, busy, frame_done, short_frame_err = 0; rd_addr, out_index, out_ux, out_uy, out_rho, node counter = 0.

Verification
REQ-038 Full frame, DEPTH=4: host_req pulse, collision phase with 4 collider_ready beats, ack each word immediately -> out_index 0,1,2,3 with matching data, capture_en 0 throughout readout, one frame_done pulse.
REQ-039 Collision already high when host_req arrives -> that phase ignored; next complete phase captured.
REQ-040 Phase with 3 beats (DEPTH=4) -> short_frame_err = 1, FSM returns to ARM, next 4-beat phase reads out normally, error still 1.
REQ-041 Host stalls ack 10 cycles on word 2 -> out_valid and out_* stable for all 10 cycles, no rd_en issued.
REQ-042 rst driven low during PRESENT of word 1 -> immediate IDLE, all outputs at reset values, capture_en = 1.
REQ-043 host_req edges during CAPTURE and PRESENT, host_ack in IDLE -> no state change, no extra words.
